// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline-side request/hit signals and RAM-side strobes of mem_arbiter.
interface mem_arbiter_if;
    logic        iREN, dREN, dWEN, ihit, dhit, ramREN, ramWEN, ram_rdy;
    logic [31:0] iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_rdy,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_rdy,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data requests onto a single-ported RAM.
// Optional fetch anti-starvation is enabled by defining MEMARB_STARVE_EN.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;
    state_t      state, next_state;
    logic        op_w, is_d, keep;
    logic [31:0] addr_q, store_q;
    logic        data_req, grant_d, grant_i, in_acc, finish, still_wanted;
    assign data_req = bus.dREN | bus.dWEN;
    assign in_acc   = (state == DACC) || (state == IACC);
    assign finish   = in_acc && bus.ram_rdy;
`ifdef MEMARB_STARVE_EN
    logic [3:0] starve;
    assign grant_i = (state == IDLE) && bus.iREN && (!data_req || starve == 4'(STARVE_MAX));
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST)
            starve <= '0;
        else
            starve <= grant_i ? '0 : grant_d ? (bus.iREN ? starve + 4'd1 : '0) : starve;
`else
    logic unused_starve;
    assign unused_starve = (STARVE_MAX != 0);
    assign grant_i = (state == IDLE) && bus.iREN && !data_req;
`endif
    assign grant_d = (state == IDLE) && data_req && !grant_i;
    // A result is kept only if the requester still asks for the same thing at completion.
    assign still_wanted = (state == DACC) ? ((op_w ? bus.dWEN : bus.dREN) && bus.daddr == addr_q)
                                          : (bus.iREN && bus.iaddr == addr_q);
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    always_comb begin
        next_state = state;
        next_state = (state == IDLE) ? (grant_d ? DACC : grant_i ? IACC : IDLE) :
                     (state == DONE) ? IDLE :
                     finish          ? DONE : state;
    end
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            op_w     <= 1'b0;
            is_d     <= 1'b0;
            keep     <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            bus.iload <= '0;
            bus.dload <= '0;
        end else begin
            if (grant_d) begin
                op_w    <= bus.dWEN;
                is_d    <= 1'b1;
                addr_q  <= bus.daddr;
                store_q <= bus.dstore;
            end else if (grant_i) begin
                op_w   <= 1'b0;
                is_d   <= 1'b0;
                addr_q <= bus.iaddr;
            end
            if (finish)
                keep <= still_wanted;
            if (finish && still_wanted && !op_w && state == DACC)
                bus.dload <= bus.ramload;
            if (finish && still_wanted && state == IACC)
                bus.iload <= bus.ramload;
        end
    always_comb begin
        bus.ramREN   = (state == IACC) || (state == DACC && !op_w);
        bus.ramWEN   = (state == DACC) && op_w;
        bus.ramaddr  = in_acc ? addr_q : '0;
        bus.ramstore = (state == DACC && op_w) ? store_q : '0;
        bus.dhit     = (state == DONE) && keep && is_d;
        bus.ihit     = (state == DONE) && keep && !is_d;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a word-level memory model.
module tb_mem_arbiter;
    localparam int SM = 2;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int total = 0;
    int bad = 0;
    mem_arbiter_if bus ();
    mem_arbiter #(.STARVE_MAX(SM)) dut (.CLK(clk), .nRST(nrst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // RAM model: ready after ram_lat strobed cycles, writes commit on the ready cycle
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int ram_lat = 1;
    int ram_wait = 0;
    bit ram_stall = 0;
    bit rnd_lat = 0;
    always @(negedge clk) begin
        bit strobe, rdy;
        strobe = bus.ramREN || bus.ramWEN;
        rdy = strobe && !ram_stall && (ram_wait >= ram_lat - 1);
        if (!strobe)
            ram_wait = 0;
        else if (rdy) begin
            ram_wait = 0;
            if (bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
            if (rnd_lat) ram_lat = $urandom_range(1, 3);
        end else
            ram_wait++;
        bus.ram_rdy = rdy;
        bus.ramload = (rdy && bus.ramREN) ? (ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr]
                                                                        : init_word(bus.ramaddr))
                                          : $urandom;
    end

    always @(negedge clk) chk("hit_overlap", 32'(bus.ihit & bus.dhit), 0);

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobes"}, 32'({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN}), 0);
        chk({tag, "_ramaddr"}, bus.ramaddr, 0);
        chk({tag, "_ramstore"}, bus.ramstore, 0);
        chk({tag, "_iload"}, bus.iload, 0);
        chk({tag, "_dload"}, bus.dload, 0);
    endtask

    initial begin
        logic [5:0] order, exp_order;
        int nh, iw, dw;
        bit ip, dp;
        logic [31:0] last_dl;
        {bus.iREN, bus.dREN, bus.dWEN} = '0;
        {bus.iaddr, bus.daddr, bus.dstore} = '0;
        repeat (2) cyc();
        chk_all_zero("rst");
        nrst = 1'b1;
        // reset in the middle of a stalled data access
        ram_stall = 1;
        bus.dREN = 1; bus.daddr = 32'h500;
        cyc(); cyc();
        chk("dacc_ramREN", 32'(bus.ramREN), 1);
        #2 nrst = 1'b0;
        #1 chk_all_zero("midrst");
        bus.dREN = 0; ram_stall = 0;
        cyc();
        nrst = 1'b1;
        ram_mem[32'h40] = 32'hDEADBEEF; ram_lat = 1;
        bus.iREN = 1; bus.iaddr = 32'h40;
        cyc();
        chk("t1_ihit_c1", 32'(bus.ihit), 0);
        chk("t1_ramREN", 32'(bus.ramREN), 1);
        cyc();
        chk("t1_ihit_c2", 32'(bus.ihit), 1);
        chk("t1_iload", bus.iload, 32'hDEADBEEF);
        bus.iREN = 0;
        cyc();
        // load with three-cycle RAM latency
        ram_mem[32'h100] = 32'h12345678; ram_lat = 3;
        bus.dREN = 1; bus.daddr = 32'h100;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            chk("t2_ramREN", 32'({bus.ramREN, bus.ramWEN, bus.dhit}), 32'b100);
            chk("t2_ramaddr", bus.ramaddr, 32'h100);
        end
        cyc();
        chk("t2_dhit", 32'(bus.dhit), 1);
        chk("t2_dload", bus.dload, 32'h12345678);
        bus.dREN = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("t2_no_repeat", 32'({bus.ramREN, bus.dhit}), 0);
        end
        // simultaneous write and fetch: write first
        ram_lat = 1;
        bus.iREN = 1; bus.iaddr = 32'h40;
        bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'hA5A5A5A5;
        cyc();
        chk("t3_ramWEN", 32'({bus.ramWEN, bus.ramREN}), 32'b10);
        chk("t3_ramstore", bus.ramstore, 32'hA5A5A5A5);
        chk("t3_ramaddr", bus.ramaddr, 32'h200);
        cyc();
        chk("t3_dhit", 32'({bus.dhit, bus.ihit}), 32'b10);
        bus.dWEN = 0;
        cyc(); cyc();
        chk("t3_fetch_ramREN", 32'(bus.ramREN), 1);
        chk("t3_fetch_addr", bus.ramaddr, 32'h40);
        cyc();
        chk("t3_ihit", 32'({bus.dhit, bus.ihit}), 32'b01);
        bus.iREN = 0;
        chk("t3_ram_written", ram_mem[32'h200], 32'hA5A5A5A5);
        cyc();
        // fetch withdrawn mid-access
        ram_mem[32'h40] = 32'h11111111; ram_lat = 3;
        bus.iREN = 1; bus.iaddr = 32'h40;
        cyc();
        chk("t4_addr40", bus.ramaddr, 32'h40);
        cyc();
        bus.iaddr = 32'h80;
        cyc(); cyc();
        chk("t4_no_ihit", 32'(bus.ihit), 0);
        chk("t4_iload_kept", bus.iload, 32'hDEADBEEF);
        cyc();
        chk("t4_idle", 32'(bus.ramREN), 0);
        cyc();
        chk("t4_reissue", 32'(bus.ramREN), 1);
        chk("t4_addr80", bus.ramaddr, 32'h80);
        cyc(); cyc(); cyc();
        chk("t4_ihit", 32'(bus.ihit), 1);
        chk("t4_iload", bus.iload, init_word(32'h80));
        bus.iREN = 0;
        cyc();
        // read and write together act as a write
        ram_lat = 1;
        bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'h0BADF00D;
        cyc();
        chk("t6_strobes", 32'({bus.ramWEN, bus.ramREN}), 32'b10);
        cyc();
        chk("t6_dhit", 32'(bus.dhit), 1);
        chk("t6_dload_kept", bus.dload, 32'h12345678);
        bus.dREN = 0; bus.dWEN = 0;
        cyc();
        // grant order with both sides continuously requesting
        bus.iREN = 1; bus.iaddr = 32'h1000;
        bus.dREN = 1; bus.daddr = 32'h2000;
        nh = 0; order = '0;
        for (int c = 0; c < 60 && nh < 6; c++) begin
            cyc();
            if (bus.dhit) begin order[nh] = 1'b0; nh++; bus.daddr = bus.daddr + 1; end
            if (bus.ihit) begin order[nh] = 1'b1; nh++; bus.iaddr = bus.iaddr + 1; end
        end
        bus.iREN = 0; bus.dREN = 0;
        for (int k = 0; k < 6; k++)
`ifdef MEMARB_STARVE_EN
            exp_order[k] = ((k + 1) % (SM + 1)) == 0;
`else
            exp_order[k] = 1'b0;
`endif
        chk("starve_hits", nh, 6);
        chk("starve_order", 32'(order), 32'(exp_order));
        cyc(); cyc();
        // randomized traffic against the memory model
        ref_mem = ram_mem;
        rnd_lat = 1;
        nh = 0; iw = 0; dw = 0; ip = 0; dp = 0;
        last_dl = bus.dload;
        repeat (3000) begin
            cyc();
            if (bus.dhit) begin
                if (bus.dWEN) begin
                    ref_mem[bus.daddr] = bus.dstore;
                    chk("rnd_dload_hold", bus.dload, last_dl);
                end else
                    chk("rnd_dload", bus.dload, ref_rd(bus.daddr));
                last_dl = bus.dload;
                dp = 0; nh++;
            end
            if (bus.ihit) begin
                chk("rnd_iload", bus.iload, ref_rd(bus.iaddr));
                ip = 0; nh++;
            end
            if (bus.ramWEN) begin
                chk("rnd_waddr", bus.ramaddr, bus.daddr);
                chk("rnd_wdata", bus.ramstore, bus.dstore);
            end
            iw = ip ? iw + 1 : 0;
            dw = dp ? dw + 1 : 0;
            if (iw == 200) chk("rnd_i_timeout", iw, 0);
            if (dw == 200) chk("rnd_d_timeout", dw, 0);
            if (!dp) begin
                if ($urandom_range(0, 2) == 0) begin
                    {bus.dWEN, bus.dREN} = 2'($urandom_range(1, 3));
                    bus.daddr = 32'($urandom_range(0, 7));
                    bus.dstore = $urandom;
                    dp = 1;
                end else
                    {bus.dWEN, bus.dREN} = 2'b00;
            end
            if (!ip) begin
                bus.iREN = 1'($urandom_range(0, 1));
                bus.iaddr = 32'($urandom_range(0, 7));
                ip = bus.iREN;
            end
        end
        chk("rnd_hits_min", 32'(nh > 200), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
